// File: rtl/mi_nios_niosge_cpu_debug_host_shifter.sv
// mi_nios_niosge_cpu_debug_host_shifter: virtual-JTAG host that runs one UIR/CDR/SDR/UDR/RTI scan per command
module mi_nios_niosge_cpu_debug_host_shifter #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV = 2,
  parameter int RTI_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);
  localparam int PW = $clog2(2 * TCK_DIV);
  localparam int BW = $clog2(DR_WIDTH);
  localparam int RW = RTI_CYCLES > 1 ? $clog2(RTI_CYCLES) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(2 * TCK_DIV - 1);
  localparam logic [PW-1:0] PH_RISE = PW'(TCK_DIV - 1);
  localparam logic [PW-1:0] PH_HIGH = PW'(TCK_DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);
  localparam logic [RW-1:0] RTI_LAST = RW'(RTI_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI} state_t;
  state_t state, nxt;
  logic [PW-1:0] ph;
  logic [BW-1:0] bc;
  logic [RW-1:0] rc;
  logic [DR_WIDTH-1:0] dsr, sr;
  logic end_p, accept, bit_last, rti_done, ir_out_unused;
  assign end_p = ph == PH_LAST;
  assign accept = cmd_valid && cmd_ready;
  assign bit_last = end_p && bc == BIT_LAST;
  assign rti_done = end_p && rc == RTI_LAST;
  assign cmd_ready = state == IDLE;
  assign vji_tck = ph >= PH_HIGH;
  assign vji_tdi = state == SDR && dsr[0];
  assign vji_uir = state == UIR;
  assign vji_cdr = state == CDR;
  assign vji_sdr = state == SDR;
  assign vji_udr = state == UDR;
  assign vji_rti = state == RTI || state == IDLE;
  assign ir_out_unused = ^vji_ir_out;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? UIR : IDLE;
      UIR:     nxt = end_p ? CDR : UIR;
      CDR:     nxt = end_p ? SDR : CDR;
      SDR:     nxt = bit_last ? UDR : SDR;
      UDR:     nxt = end_p ? RTI : UDR;
      RTI:     nxt = rti_done ? IDLE : RTI;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ph <= '0;
      bc <= '0;
      rc <= '0;
      dsr <= '0;
      sr <= '0;
      vji_ir_in <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
    end else begin
      state <= nxt;
      ph <= (state == IDLE || end_p) ? '0 : ph + 1'b1;
      bc <= (state == SDR && end_p) ? (bit_last ? '0 : bc + 1'b1) : bc;
      rc <= (state == RTI && end_p) ? (rti_done ? '0 : rc + 1'b1) : rc;
      rsp_valid <= state == RTI && rti_done;
      if (accept) begin
        vji_ir_in <= cmd_ir;
        dsr <= cmd_data;
      end else if (state == SDR && end_p) begin
        dsr <= dsr >> 1;
      end
      if (state == SDR && ph == PH_RISE) sr <= {vji_tdo, sr[DR_WIDTH-1:1]};
      if (state == RTI && rti_done) rsp_data <= sr;
    end
  end
endmodule

// File: tb/tb_mi_nios_niosge_cpu_debug_host_shifter.sv
// tb_mi_nios_niosge_cpu_debug_host_shifter: self-checking bench for the virtual-JTAG host shifter
module tb_mi_nios_niosge_cpu_debug_host_shifter;
  localparam int DW = 38;
  localparam int LAT = 173;
  localparam int LAT1 = 85;
  localparam logic [DW-1:0] INIT1 = 38'h1234567890;
  typedef struct {logic [1:0] ir; logic [DW-1:0] data; logic [DW-1:0] init;} vec_t;
  typedef struct {logic [1:0] ir; logic [DW-1:0] data; logic [DW-1:0] rsp; int acc;} exp_t;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic cmd_valid = 0, cmd_ready, rsp_valid;
  logic [1:0] cmd_ir = 0, vji_ir_in;
  logic [DW-1:0] cmd_data = 0, rsp_data;
  logic vji_tck, vji_tdi, vji_tdo, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic c1_valid = 0, c1_ready, r1_valid;
  logic [1:0] c1_ir = 0, t1_ir_in;
  logic [DW-1:0] c1_data = 0, r1_data;
  logic t1_tck, t1_tdi, t1_tdo, t1_uir, t1_cdr, t1_sdr, t1_udr, t1_rti;
  mi_nios_niosge_cpu_debug_host_shifter dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .vji_tck(vji_tck),
    .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in), .vji_ir_out(2'b00),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
  );
  mi_nios_niosge_cpu_debug_host_shifter #(.TCK_DIV(1), .RTI_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_ir(c1_ir),
    .cmd_data(c1_data), .rsp_valid(r1_valid), .rsp_data(r1_data), .vji_tck(t1_tck),
    .vji_tdi(t1_tdi), .vji_tdo(t1_tdo), .vji_ir_in(t1_ir_in), .vji_ir_out(2'b00),
    .vji_uir(t1_uir), .vji_cdr(t1_cdr), .vji_sdr(t1_sdr), .vji_udr(t1_udr), .vji_rti(t1_rti)
  );
  logic [DW-1:0] ssr = '0, ssr1 = '0, s_init = '0, tdi_cap = '0;
  int shifts = 0;
  always @(posedge vji_tck) begin
    if (vji_cdr) begin
      ssr <= s_init;
      shifts <= 0;
    end else if (vji_sdr) begin
      ssr <= {vji_tdi, ssr[DW-1:1]};
      tdi_cap <= {vji_tdi, tdi_cap[DW-1:1]};
      shifts <= shifts + 1;
    end
  end
  assign vji_tdo = ssr[0];
  always @(posedge t1_tck) begin
    if (t1_cdr) ssr1 <= INIT1;
    else if (t1_sdr) ssr1 <= {t1_tdi, ssr1[DW-1:1]};
  end
  assign t1_tdo = ssr1[0];
  int tests = 0, fails = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic chk_rst(input string n);
    chk(n, {cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 11'b10000000001);
    chk({n, " data"}, rsp_data, 0);
    chk({n, " dut1"}, {c1_ready, r1_valid, t1_tck, t1_rti}, 4'b1001);
  endtask
  exp_t q[$];
  exp_t e;
  int d;
  logic prev_sdr = 0;
  always @(negedge clk) begin
    if (!reset) begin
      chk("flags onehot", $countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 1);
      if (rsp_valid) begin
        chk("rsp outstanding", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("rsp data", rsp_data, e.rsp);
          chk("rsp latency", cyc - e.acc, LAT);
        end
      end
      if (cmd_valid && cmd_ready) q.push_back('{ir: cmd_ir, data: cmd_data, rsp: s_init, acc: cyc});
      if (q.size() > 0) begin
        d = cyc - q[$].acc;
        if (d == 1) chk("ir_in at uir", vji_ir_in, q[$].ir);
        if (d >= 1 && d <= 4) chk("tck phase", vji_tck, d >= 3);
      end
      if (vji_udr && prev_sdr && q.size() > 0) begin
        chk("tdi sequence", tdi_cap, q[0].data);
        chk("slave sr at udr", ssr, q[0].data);
      end
      prev_sdr = vji_sdr;
    end
  end
  task automatic wait_rsp();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 400);
    chk("rsp arrives", rsp_valid, 1);
  endtask
  task automatic send(input vec_t v);
    @(posedge clk); #1;
    s_init = v.init;
    cmd_ir = v.ir;
    cmd_data = v.data;
    cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    wait_rsp();
  endtask
  vec_t vt[5];
  initial begin
    int n, c0, a1;
    vt[0] = '{2'b01, 38'h2A5A5A5A5A, 38'h00DEADBEEF};
    vt[1] = '{2'b00, 38'h0, 38'h3FFFFFFFFF};
    vt[2] = '{2'b11, 38'h3FFFFFFFFF, 38'h0};
    vt[3] = '{2'b10, 38'h1555555555, 38'h2AAAAAAAAA};
    vt[4] = '{2'($urandom), DW'({$urandom, $urandom}), DW'({$urandom, $urandom})};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'($urandom);
      cmd_ir = 2'($urandom);
      cmd_data = DW'({$urandom, $urandom});
      @(negedge clk);
      chk_rst("reset hold");
    end
    @(posedge clk); #1;
    cmd_valid = 0;
    reset = 0;
    @(negedge clk);
    chk("ready after reset", cmd_ready, 1);
    for (int i = 0; i < 5; i++) begin
      send(vt[i]);
      repeat (2) @(negedge clk);
      chk("rsp held", rsp_data, vt[i].init);
    end
    @(posedge clk); #1;
    s_init = 38'h0F0F0F0F0F;
    cmd_ir = 2'b10;
    cmd_data = 38'h123456789A;
    cmd_valid = 1;
    @(negedge clk);
    c0 = cyc;
    @(posedge clk); #1;
    cmd_ir = 2'b11;
    cmd_data = 38'h3456789ABC;
    wait_rsp();
    chk("b2b first rsp cycle", cyc - c0, LAT);
    chk("b2b ready on rsp", cmd_ready, 1);
    chk("b2b ir held", vji_ir_in, 2'b10);
    @(posedge clk); #1;
    cmd_valid = 0;
    @(negedge clk);
    chk("b2b ir switch", vji_ir_in, 2'b11);
    chk("b2b second busy", cmd_ready, 0);
    wait_rsp();
    chk("b2b second rsp cycle", cyc - c0, 2 * LAT);
    @(posedge clk); #1;
    s_init = 38'h1111111111;
    cmd_ir = 2'b01;
    cmd_data = 38'h0123456789;
    cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    n = 0;
    while (!(vji_sdr && shifts == 10) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ten shifts reached", shifts, 10);
    #2 reset = 1;
    #1 chk_rst("reset mid sdr");
    q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    send(vt[0]);
    @(posedge clk); #1;
    s_init = vt[3].init;
    cmd_ir = vt[3].ir;
    cmd_data = vt[3].data;
    cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    n = 0;
    while (!vji_sdr && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached sdr", vji_sdr, 1);
    @(posedge clk); #1;
    cmd_valid = 1;
    cmd_ir = 2'b00;
    cmd_data = 38'h3FFFFFFFFF;
    @(negedge clk);
    chk("busy ready low", cmd_ready, 0);
    @(posedge clk); #1;
    cmd_valid = 0;
    wait_rsp();
    chk("ir after ignored cmd", vji_ir_in, vt[3].ir);
    @(posedge clk); #1;
    c1_ir = 2'b01;
    c1_data = 38'h2A5A5A5A5A;
    c1_valid = 1;
    @(negedge clk);
    a1 = cyc;
    chk("d1 ready", c1_ready, 1);
    @(posedge clk); #1;
    c1_valid = 0;
    @(negedge clk);
    chk("d1 tck low", t1_tck, 0);
    chk("d1 ir_in", t1_ir_in, 2'b01);
    @(negedge clk);
    chk("d1 tck high", t1_tck, 1);
    n = 0;
    while (!r1_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("d1 rsp cycle", cyc - a1, LAT1);
    chk("d1 rsp data", r1_data, INIT1);
    chk("d1 slave sr", ssr1, 38'h2A5A5A5A5A);
    repeat (3) @(negedge clk);
    chk("queue drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mi_nios_niosge_cpu_debug_host_shifter.md
# mi_nios_niosGe_cpu_debug_host_shifter

Host-side initiator for the Nios II debug slave's virtual-JTAG channel. It takes one IR/DR command per transaction and drives the virtual TAP state flags, TCK and TDI the way the SLD hub would: UIR, CDR, a DR_WIDTH-bit SDR shift, UDR, then RTI. It returns the DR bits the slave shifted out. It sits in the simulation/self-test harness, wired directly to the slave's vji_* nets in place of sld_virtual_jtag_basic.

## Interface
- DR_WIDTH, default 38: scan-register length (matches jdo/sr); must be ≥2.
- IR_WIDTH, default 2: virtual IR width.
- TCK_DIV, default 2: clk cycles per TCK half-period; must be ≥1.
- RTI_CYCLES, default 2: TCK periods spent in RTI after UDR, so the sysclk side can see the update; must be ≥1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_ir  in  IR_WIDTH  virtual IR value for the command.
- cmd_data  in  DR_WIDTH  DR value; shifted LSB first.
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid.
- rsp_data  out  DR_WIDTH  DR bits captured from vji_tdo, held until the next response.
- vji_tck  out  1  generated TCK.
- vji_tdi  out  1  serial data to the slave.
- vji_tdo  in  1  serial data from the slave.
- vji_ir_in  out  IR_WIDTH  IR presented to the slave.
- vji_ir_out  in  IR_WIDTH  unused; tie-off only.
- vji_uir, vji_cdr, vji_sdr, vji_udr  out  1  one-hot virtual state flags.
- vji_rti  out  1  TAP in Run-Test/Idle.

## Operation
- States: IDLE, UIR, CDR, SDR, UDR, RTI.
- Accept: a command is accepted on the clk edge where cmd_valid && cmd_ready. cmd_ir and cmd_data are latched at that edge, and the block enters UIR.
- TCK period: each state occupies whole TCK periods of 2*TCK_DIV clk cycles. TCK is low for the first TCK_DIV cycles and high for the second TCK_DIV cycles.
- State outputs: the state, the flags and vji_tdi change only at a period start, while TCK is low.
- Period counts: UIR, CDR and UDR each last 1 period. SDR lasts DR_WIDTH periods. RTI lasts RTI_CYCLES periods.
- Transaction length: P = DR_WIDTH+3+RTI_CYCLES periods, which is 43 at the defaults.
- UIR: vji_uir=1. vji_ir_in loads the latched cmd_ir at the UIR period start and stays stable until the next UIR.
- CDR: vji_cdr=1.
- SDR: vji_sdr=1. In shift period k (0..DR_WIDTH-1), vji_tdi = cmd_data[k].
- TDO sampling: vji_tdo is sampled on the clk edge that drives TCK high, before the slave shifts. Sample k lands in rsp_data bit k through a right-shift register, with the new bit entering at the MSB.
- UDR: vji_udr=1. vji_tdi=0 outside SDR.
- RTI and IDLE: vji_rti=1 in both, and all other flags are 0.
- Idle state: in IDLE, vji_tck is held at 0.
- End of transaction: at the end of the last RTI period the block enters IDLE, pulses rsp_valid for one cycle with the full rsp_data, and asserts cmd_ready in the same cycle.
- Busy: cmd_valid while busy is ignored.
- vji_ir_out is ignored.
- Counters: the bit counter is $clog2(DR_WIDTH) bits and the phase counter is $clog2(2*TCK_DIV) bits. Both wrap only under state control and never free-run.

## Timing
- Reset values, asynchronous on reset, including mid-transaction:
  - state=IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0.
  - vji_tck=0, vji_tdi=0, vji_ir_in=0.
  - vji_uir, vji_cdr, vji_sdr, vji_udr = 0; vji_rti=1.
  - Any partial response is discarded.
- Cycle numbering: acceptance edge = cycle 0.
- UIR flags are valid from cycle 1. Period p starts at cycle 1+p*2*TCK_DIV. TCK rises at cycle 1+p*2*TCK_DIV+TCK_DIV.
- rsp_valid is high in cycle 1+P*2*TCK_DIV: 173 at the defaults, 87 with TCK_DIV=1.
- Back-to-back: with cmd_valid held high, the next command is accepted on the rsp_valid cycle, giving zero idle periods.
- Flags are never simultaneously high. Exactly one of uir, cdr, sdr, udr, rti is high in every non-IDLE cycle.

## Test plan
- Reset: assert reset for 3 cycles with random inputs -> all outputs at their reset values, and cmd_ready=1 the cycle after release.
- Single command against a behavioural slave (sr loads 38'h00DEADBEEF at CDR, shifts right with tdi into the MSB):
  - stimulus: cmd_ir=2'b01, cmd_data=38'h2A5A5A5A5A.
  - required: vji_ir_in=01 from cycle 1; the tdi sequence equals cmd_data LSB first.
  - required: the model's sr equals 38'h2A5A5A5A5A at UDR; rsp_data=38'h00DEADBEEF with rsp_valid at cycle 173.
- Back-to-back: two commands, ir 2'b10 then 2'b11, with cmd_valid held:
  - the second is accepted at cycle 173.
  - vji_ir_in changes to 11 only at cycle 174.
  - the second rsp_valid arrives at cycle 346.
- Reset after 10 SDR shifts -> all outputs at reset values in the same cycle. A fresh command afterwards completes correctly in 173 cycles.
- TCK_DIV=1 and RTI_CYCLES=1: TCK period is 2 clk and rsp_valid arrives at cycle 1+42*2=85.
- cmd_valid pulsed with new data during SDR -> ignored; the response and shifted data still belong to the first command.
